ad7606_par_capture: RTL and testbench

//  Parametrised AD7606-family parallel-bus capture engine. Generates CONVST, waits for BUSY,

---
 rtl/ad7606_par_capture_if.sv | 33 +++
 rtl/ad7606_par_capture.sv | 164 ++++++++++++++++
 tb/tb_ad7606_par_capture.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7606_par_capture_if.sv
// Signal bundle between the AD7606 capture engine, the ADC pins and the downstream consumers.
// master = capture engine side, slave = ADC/trigger/consumer side.
interface ad7606_par_capture_if #(
   parameter int CH_NUM = 8,
   parameter int DATA_W = 16
);
   logic                     start_i;
   logic                     convst_o;
   logic                     busy_i;
   logic                     cs_o;
   logic                     rd_o;
   logic [DATA_W-1:0]        ad_data_i;
   logic                     sample_valid_o;
   logic [3:0]               sample_ch_o;
   logic [DATA_W-1:0]        sample_data_o;
   logic                     frame_valid_o;
   logic [CH_NUM*DATA_W-1:0] frame_data_o;
   logic                     busy_o;
   logic                     tmo_err_o;
   logic                     overrun_o;

   modport master (
      input  start_i, busy_i, ad_data_i,
      output convst_o, cs_o, rd_o, sample_valid_o, sample_ch_o, sample_data_o,
             frame_valid_o, frame_data_o, busy_o, tmo_err_o, overrun_o
   );

   modport slave (
      output start_i, busy_i, ad_data_i,
      input  convst_o, cs_o, rd_o, sample_valid_o, sample_ch_o, sample_data_o,
             frame_valid_o, frame_data_o, busy_o, tmo_err_o, overrun_o
   );
endinterface

// File: rtl/ad7606_par_capture.sv
// AD7606-family parallel capture engine: CONVST pulse, BUSY handshake with timeout,
// CH_NUM RD/CS word reads into a per-sample stream and a packed frame.
//
//   state  | meaning
//   IDLE   | waiting for start_i
//   CONV   | convst_o low for CONV_LOW cycles
//   WAIT_H | waiting for synchronised BUSY to rise (timeout -> ERR)
//   WAIT_L | waiting for synchronised BUSY to fall (timeout -> ERR)
//   READ   | CH_NUM words, each RD_LOW_CYC low + RD_HIGH_CYC high
//   DONE   | one cycle, frame_valid_o
//   ERR    | one cycle, sets sticky tmo_err_o
module ad7606_par_capture #(
   parameter int CH_NUM      = 8,
   parameter int DATA_W      = 16,
   parameter int CONV_LOW    = 4,
   parameter int RD_LOW_CYC  = 2,
   parameter int RD_HIGH_CYC = 2,
   parameter int BUSY_TMO    = 4096,
   parameter int CS_MODE     = 0
) (
   input logic                  sys_clk_i,
   input logic                  rst_i,
   ad7606_par_capture_if.master bus
);

   localparam int WORD_CYC = RD_LOW_CYC + RD_HIGH_CYC;
   localparam int CNT_MAX0 = (CONV_LOW > WORD_CYC) ? CONV_LOW : WORD_CYC;
   localparam int CNT_MAX  = (BUSY_TMO > CNT_MAX0) ? BUSY_TMO : CNT_MAX0;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CONV_LD = CNT_W'(CONV_LOW - 1);
   localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(BUSY_TMO - 1);
   localparam logic [CNT_W-1:0] WORD_LD = CNT_W'(WORD_CYC - 1);
   localparam logic [CNT_W-1:0] RD_HI   = CNT_W'(RD_HIGH_CYC);
   localparam logic [3:0]       CH_LAST = 4'(CH_NUM - 1);

   if (CH_NUM < 1 || CH_NUM > 16) begin : g_ch_num_check
      $error("ad7606_par_capture: CH_NUM must be within 1..16");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CONV, S_WAIT_H, S_WAIT_L, S_READ, S_DONE, S_ERR
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       ch, ch_nxt;
   logic [1:0]       busy_sync;
   logic             busy_s;
   logic             convst_nxt, rd_nxt, cs_nxt, busy_nxt, fv_nxt, capture;

   assign busy_s = busy_sync[1];

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state              <= S_IDLE;
         cnt                <= '0;
         ch                 <= '0;
         busy_sync          <= '0;
         bus.convst_o       <= 1'b1;
         bus.cs_o           <= 1'b1;
         bus.rd_o           <= 1'b1;
         bus.busy_o         <= 1'b0;
         bus.frame_valid_o  <= 1'b0;
         bus.sample_valid_o <= 1'b0;
         bus.sample_ch_o    <= '0;
         bus.sample_data_o  <= '0;
         bus.frame_data_o   <= '0;
         bus.tmo_err_o      <= 1'b0;
         bus.overrun_o      <= 1'b0;
      end else begin
         state              <= state_nxt;
         cnt                <= cnt_nxt;
         ch                 <= ch_nxt;
         busy_sync          <= {busy_sync[0], bus.busy_i};
         bus.convst_o       <= convst_nxt;
         bus.cs_o           <= cs_nxt;
         bus.rd_o           <= rd_nxt;
         bus.busy_o         <= busy_nxt;
         bus.frame_valid_o  <= fv_nxt;
         bus.sample_valid_o <= capture;
         bus.overrun_o      <= bus.start_i && bus.busy_o;
         if (capture) begin
            bus.sample_ch_o   <= ch;
            bus.sample_data_o <= bus.ad_data_i;
            for (int i = 0; i < CH_NUM; i++) begin
               if (ch == 4'(i)) bus.frame_data_o[i*DATA_W +: DATA_W] <= bus.ad_data_i;
            end
         end
         if (state_nxt == S_ERR) bus.tmo_err_o <= 1'b1;
      end
   end

   // cnt is a down-counter reused as CONV width, BUSY timeout and RD word phase.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ch_nxt    = ch;
      case (state)
         S_IDLE: begin
            if (bus.start_i) begin
               state_nxt = S_CONV;
               cnt_nxt   = CONV_LD;
               ch_nxt    = '0;
            end
         end
         S_CONV: begin
            if (cnt == '0) begin
               state_nxt = S_WAIT_H;
               cnt_nxt   = TMO_LD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_WAIT_H: begin
            if (busy_s) begin
               state_nxt = S_WAIT_L;
               cnt_nxt   = TMO_LD;
            end else if (cnt == '0) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_WAIT_L: begin
            if (!busy_s) begin
               state_nxt = S_READ;
               cnt_nxt   = WORD_LD;
               ch_nxt    = '0;
            end else if (cnt == '0) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_READ: begin
            if (cnt == '0) begin
               if (ch == CH_LAST) begin
                  state_nxt = S_DONE;
               end else begin
                  ch_nxt  = ch + 4'd1;
                  cnt_nxt = WORD_LD;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so they line up with the state register.
   always_comb begin
      convst_nxt = (state_nxt != S_CONV);
      rd_nxt     = !((state_nxt == S_READ) && (cnt_nxt >= RD_HI));
      cs_nxt     = (CS_MODE != 0) ? (state_nxt != S_READ) : rd_nxt;
      busy_nxt   = (state_nxt != S_IDLE);
      fv_nxt     = (state_nxt == S_DONE);
      capture    = (state == S_READ) && (cnt == RD_HI);
   end

endmodule

// File: tb/tb_ad7606_par_capture.sv
// Directed bench for ad7606_par_capture: four configurations share one clock and reset,
// each with a small ADC model (BUSY pulse after CONVST, data = base + word index).
module tb_ad7606_par_capture;

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;
   int   errors  = 0;
   int   checks  = 0;

   always #5 sys_clk = ~sys_clk;

   ad7606_par_capture_if #(.CH_NUM(8), .DATA_W(16)) if0 ();
   ad7606_par_capture_if #(.CH_NUM(8), .DATA_W(16)) if1 ();
   ad7606_par_capture_if #(.CH_NUM(4), .DATA_W(16)) if2 ();
   ad7606_par_capture_if #(.CH_NUM(1), .DATA_W(16)) if3 ();

   ad7606_par_capture u0 (.sys_clk_i(sys_clk), .rst_i(rst), .bus(if0));
   ad7606_par_capture #(.BUSY_TMO(64)) u1 (.sys_clk_i(sys_clk), .rst_i(rst), .bus(if1));
   ad7606_par_capture #(.CH_NUM(4), .RD_LOW_CYC(3), .RD_HIGH_CYC(1), .CS_MODE(1))
      u2 (.sys_clk_i(sys_clk), .rst_i(rst), .bus(if2));
   ad7606_par_capture #(.CH_NUM(1)) u3 (.sys_clk_i(sys_clk), .rst_i(rst), .bus(if3));

   // ADC data models: word index advances on each rd_o rising edge, cleared by CONVST.
   logic [3:0] widx0, widx2, widx3;
   logic       rd0_q, rd2_q, rd3_q;
   assign if0.ad_data_i = 16'h1000 + {12'h000, widx0};
   assign if2.ad_data_i = 16'h2000 + {12'h000, widx2};
   assign if3.ad_data_i = 16'h3000 + {12'h000, widx3};
   assign if1.ad_data_i = 16'h0000;
   assign if1.busy_i    = 1'b0;

   always @(negedge sys_clk) begin
      if (!if0.convst_o) widx0 = '0; else if (if0.rd_o && !rd0_q) widx0 = widx0 + 4'd1;
      if (!if2.convst_o) widx2 = '0; else if (if2.rd_o && !rd2_q) widx2 = widx2 + 4'd1;
      if (!if3.convst_o) widx3 = '0; else if (if3.rd_o && !rd3_q) widx3 = widx3 + 4'd1;
      rd0_q = if0.rd_o;
      rd2_q = if2.rd_o;
      rd3_q = if3.rd_o;
   end

   // BUSY models: rise 2 cycles after CONVST returns high, stay high 10 cycles.
   initial begin
      if0.busy_i = 1'b0;
      forever begin
         @(negedge if0.convst_o);
         @(posedge if0.convst_o);
         repeat (2) @(posedge sys_clk);
         #1 if0.busy_i = 1'b1;
         repeat (10) @(posedge sys_clk);
         #1 if0.busy_i = 1'b0;
      end
   end

   initial begin
      if2.busy_i = 1'b0;
      forever begin
         @(negedge if2.convst_o);
         @(posedge if2.convst_o);
         repeat (2) @(posedge sys_clk);
         #1 if2.busy_i = 1'b1;
         repeat (10) @(posedge sys_clk);
         #1 if2.busy_i = 1'b0;
      end
   end

   initial begin
      if3.busy_i = 1'b0;
      forever begin
         @(negedge if3.convst_o);
         @(posedge if3.convst_o);
         repeat (2) @(posedge sys_clk);
         #1 if3.busy_i = 1'b1;
         repeat (10) @(posedge sys_clk);
         #1 if3.busy_i = 1'b0;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({if0.convst_o, if0.cs_o, if0.rd_o} !== 3'b111) begin
         errors++;
         $display("FAIL reset_pins: got %b want 111", {if0.convst_o, if0.cs_o, if0.rd_o});
      end
      checks++;
      if ({if0.sample_valid_o, if0.frame_valid_o, if0.busy_o, if0.tmo_err_o, if0.overrun_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000",
                  {if0.sample_valid_o, if0.frame_valid_o, if0.busy_o, if0.tmo_err_o, if0.overrun_o});
      end
      checks++;
      if (if0.sample_ch_o !== 4'd0 || if0.sample_data_o !== 16'd0) begin
         errors++;
         $display("FAIL reset_sample: got ch=%0d data=%h want 0/0000", if0.sample_ch_o, if0.sample_data_o);
      end
      checks++;
      if (if0.frame_data_o !== 128'd0) begin
         errors++;
         $display("FAIL reset_frame: got %h want 0", if0.frame_data_o);
      end
      checks++;
      if (if2.cs_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_cs_mode1: got %b want 1", if2.cs_o);
      end
      rst = 1'b0;
      repeat (20) @(negedge sys_clk);
      checks++;
      if (if0.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy_o got %b want 0", if0.busy_o);
      end
   endtask

   task automatic test_frame();
      int conv_low, ns, nf, cs_bad;
      logic [127:0] exp_frame;
      conv_low = 0; ns = 0; nf = 0; cs_bad = 0;
      for (int k = 0; k < 8; k++) exp_frame[k*16 +: 16] = 16'h1000 + 16'(k);
      if0.start_i = 1'b1;
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge sys_clk);
         if0.start_i = 1'b0;
         if (!if0.convst_o) conv_low++;
         if (if0.cs_o !== if0.rd_o) cs_bad++;
         if (if0.frame_valid_o) nf++;
         if (if0.sample_valid_o) begin
            checks++;
            if (if0.sample_ch_o !== 4'(ns) || if0.sample_data_o !== 16'h1000 + 16'(ns)) begin
               errors++;
               $display("FAIL frame_sample%0d: got ch=%0d data=%h want ch=%0d data=%h",
                        ns, if0.sample_ch_o, if0.sample_data_o, ns, 16'h1000 + 16'(ns));
            end
            ns++;
         end
      end
      checks++;
      if (conv_low != 4) begin errors++; $display("FAIL convst_width: got %0d want 4", conv_low); end
      checks++;
      if (ns != 8) begin errors++; $display("FAIL sample_count: got %0d want 8", ns); end
      checks++;
      if (nf != 1) begin errors++; $display("FAIL frame_valid_count: got %0d want 1", nf); end
      checks++;
      if (cs_bad != 0) begin errors++; $display("FAIL cs_eq_rd: got %0d bad cycles want 0", cs_bad); end
      checks++;
      if (if0.frame_data_o[63:48] !== 16'h1003) begin
         errors++;
         $display("FAIL frame_ch3: got %h want 1003", if0.frame_data_o[63:48]);
      end
      checks++;
      if (if0.frame_data_o !== exp_frame) begin
         errors++;
         $display("FAIL frame_data: got %h want %h", if0.frame_data_o, exp_frame);
      end
      checks++;
      if (if0.busy_o !== 1'b0 || if0.tmo_err_o !== 1'b0) begin
         errors++;
         $display("FAIL frame_end_status: got busy=%b tmo=%b want 0/0", if0.busy_o, if0.tmo_err_o);
      end
   endtask

   task automatic test_timeout();
      int conv_end, tmo_at, nfv, nsv, rd_low;
      logic seen_low, busy_after;
      conv_end = -1; tmo_at = -1; nfv = 0; nsv = 0; rd_low = 0;
      seen_low = 1'b0; busy_after = 1'bx;
      if1.start_i = 1'b1;
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge sys_clk);
         if1.start_i = 1'b0;
         if (!if1.convst_o) seen_low = 1'b1;
         else if (seen_low && conv_end < 0) conv_end = cyc;
         if (if1.tmo_err_o && tmo_at < 0) tmo_at = cyc;
         if (tmo_at >= 0 && cyc == tmo_at + 1) busy_after = if1.busy_o;
         if (if1.frame_valid_o) nfv++;
         if (if1.sample_valid_o) nsv++;
         if (!if1.rd_o) rd_low++;
      end
      checks++;
      if (conv_end < 0 || tmo_at < 0 || tmo_at - conv_end != 64) begin
         errors++;
         $display("FAIL tmo_wait: got conv_end=%0d tmo_at=%0d want gap 64", conv_end, tmo_at);
      end
      checks++;
      if (if1.tmo_err_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", if1.tmo_err_o); end
      checks++;
      if (busy_after !== 1'b0) begin errors++; $display("FAIL tmo_busy_drop: got %b want 0", busy_after); end
      checks++;
      if (nfv != 0 || nsv != 0 || rd_low != 0) begin
         errors++;
         $display("FAIL tmo_no_frame: got fv=%0d sv=%0d rd_low=%0d want 0/0/0", nfv, nsv, rd_low);
      end
   endtask

   task automatic test_overrun();
      int ns, nf, inj, nov, conv_low;
      logic [127:0] exp_frame;
      ns = 0; nf = 0; inj = 0; nov = 0; conv_low = 0;
      for (int k = 0; k < 8; k++) exp_frame[k*16 +: 16] = 16'h1000 + 16'(k);
      if0.start_i = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge sys_clk);
         if (cyc == 0) if0.start_i = 1'b0;
         if (!if0.convst_o) conv_low++;
         if (if0.overrun_o) nov++;
         if (if0.frame_valid_o) nf++;
         if (inj == 1) begin
            checks++;
            if (if0.overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b want 1", if0.overrun_o); end
            if0.start_i = 1'b0;
            inj = 2;
         end else if (inj == 2) begin
            checks++;
            if (if0.overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", if0.overrun_o); end
            inj = 3;
         end
         if (if0.sample_valid_o) begin
            checks++;
            if (if0.sample_data_o !== 16'h1000 + 16'(ns)) begin
               errors++;
               $display("FAIL ovr_sample%0d: got %h want %h", ns, if0.sample_data_o, 16'h1000 + 16'(ns));
            end
            ns++;
            if (ns == 2 && inj == 0) begin
               if0.start_i = 1'b1;
               inj = 1;
            end
         end
      end
      checks++;
      if (inj != 3 || nov != 1) begin errors++; $display("FAIL overrun_seq: got inj=%0d pulses=%0d want 3/1", inj, nov); end
      checks++;
      if (ns != 8 || nf != 1) begin errors++; $display("FAIL ovr_frame: got samples=%0d fv=%0d want 8/1", ns, nf); end
      checks++;
      if (conv_low != 4) begin errors++; $display("FAIL ovr_no_retrigger: convst low got %0d want 4", conv_low); end
      checks++;
      if (if0.frame_data_o !== exp_frame) begin
         errors++;
         $display("FAIL ovr_frame_data: got %h want %h", if0.frame_data_o, exp_frame);
      end
   endtask

   task automatic test_cs_mode();
      int cs_low, cs_falls, rd_falls, run, bad_width, rd_wo_cs, ns, nf;
      logic cs_q, rd_q;
      logic [63:0] exp_frame;
      cs_low = 0; cs_falls = 0; rd_falls = 0; run = 0; bad_width = 0; rd_wo_cs = 0; ns = 0; nf = 0;
      cs_q = 1'b1; rd_q = 1'b1;
      exp_frame = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
      if2.start_i = 1'b1;
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge sys_clk);
         if2.start_i = 1'b0;
         if (!if2.cs_o) cs_low++;
         if (cs_q && !if2.cs_o) cs_falls++;
         if (rd_q && !if2.rd_o) rd_falls++;
         if (!if2.rd_o) run++;
         if (!rd_q && if2.rd_o) begin
            if (run != 3) bad_width++;
            run = 0;
         end
         if (!if2.rd_o && if2.cs_o) rd_wo_cs++;
         cs_q = if2.cs_o;
         rd_q = if2.rd_o;
         if (if2.frame_valid_o) nf++;
         if (if2.sample_valid_o) begin
            checks++;
            if (if2.sample_ch_o !== 4'(ns) || if2.sample_data_o !== 16'h2000 + 16'(ns)) begin
               errors++;
               $display("FAIL cs1_sample%0d: got ch=%0d data=%h want ch=%0d data=%h",
                        ns, if2.sample_ch_o, if2.sample_data_o, ns, 16'h2000 + 16'(ns));
            end
            ns++;
         end
      end
      checks++;
      if (cs_low != 16 || cs_falls != 1) begin
         errors++;
         $display("FAIL cs1_window: got low=%0d falls=%0d want 16/1", cs_low, cs_falls);
      end
      checks++;
      if (rd_falls != 4 || bad_width != 0) begin
         errors++;
         $display("FAIL cs1_rd_pulses: got pulses=%0d bad_width=%0d want 4/0", rd_falls, bad_width);
      end
      checks++;
      if (rd_wo_cs != 0) begin errors++; $display("FAIL cs1_rd_outside_cs: got %0d want 0", rd_wo_cs); end
      checks++;
      if (ns != 4 || nf != 1 || if2.frame_data_o !== exp_frame) begin
         errors++;
         $display("FAIL cs1_frame: got samples=%0d fv=%0d data=%h want 4/1/%h", ns, nf, if2.frame_data_o, exp_frame);
      end
   endtask

   task automatic test_single();
      int sv_at, fv_at, rd_falls, rd_low, ns, nf;
      logic rd_q;
      sv_at = -100; fv_at = -1; rd_falls = 0; rd_low = 0; ns = 0; nf = 0; rd_q = 1'b1;
      if3.start_i = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge sys_clk);
         if3.start_i = 1'b0;
         if (!if3.rd_o) rd_low++;
         if (rd_q && !if3.rd_o) rd_falls++;
         rd_q = if3.rd_o;
         if (if3.frame_valid_o) begin nf++; fv_at = cyc; end
         if (if3.sample_valid_o) begin
            ns++;
            sv_at = cyc;
            checks++;
            if (if3.sample_ch_o !== 4'd0 || if3.sample_data_o !== 16'h3000) begin
               errors++;
               $display("FAIL single_sample: got ch=%0d data=%h want 0/3000", if3.sample_ch_o, if3.sample_data_o);
            end
         end
      end
      checks++;
      if (rd_falls != 1 || rd_low != 2 || ns != 1) begin
         errors++;
         $display("FAIL single_rd: got pulses=%0d low=%0d samples=%0d want 1/2/1", rd_falls, rd_low, ns);
      end
      checks++;
      if (nf != 1 || fv_at - sv_at != 2) begin
         errors++;
         $display("FAIL single_fv_timing: got fv=%0d gap=%0d want 1/2", nf, fv_at - sv_at);
      end
      checks++;
      if (if3.frame_data_o !== 16'h3000) begin
         errors++;
         $display("FAIL single_frame: got %h want 3000", if3.frame_data_o);
      end
   endtask

   task automatic test_reset_mid();
      int ns, nfv, nbusy;
      logic hit;
      ns = 0; nfv = 0; nbusy = 0; hit = 1'b0;
      if0.start_i = 1'b1;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         @(negedge sys_clk);
         if0.start_i = 1'b0;
         if (if0.sample_valid_o) ns++;
         if (ns == 4 && !if0.rd_o) begin
            rst = 1'b1;
            hit = 1'b1;
         end
      end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach_word5: got %b want 1", hit); end
      @(negedge sys_clk);
      checks++;
      if ({if0.convst_o, if0.cs_o, if0.rd_o} !== 3'b111 ||
          {if0.sample_valid_o, if0.frame_valid_o, if0.busy_o, if0.overrun_o} !== 4'b0) begin
         errors++;
         $display("FAIL rstmid_pins: got pins=%b flags=%b want 111/0000", {if0.convst_o, if0.cs_o, if0.rd_o},
                  {if0.sample_valid_o, if0.frame_valid_o, if0.busy_o, if0.overrun_o});
      end
      checks++;
      if (if0.sample_ch_o !== 4'd0 || if0.sample_data_o !== 16'd0 || if0.frame_data_o !== 128'd0) begin
         errors++;
         $display("FAIL rstmid_data: got ch=%0d data=%h frame=%h want 0", if0.sample_ch_o, if0.sample_data_o,
                  if0.frame_data_o);
      end
      rst = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge sys_clk);
         if (if0.frame_valid_o) nfv++;
         if (if0.busy_o) nbusy++;
      end
      checks++;
      if (nfv != 0 || nbusy != 0) begin
         errors++;
         $display("FAIL rstmid_no_frame: got fv=%0d busy_cycles=%0d want 0/0", nfv, nbusy);
      end
   endtask

   initial begin
      if0.start_i = 1'b0;
      if1.start_i = 1'b0;
      if2.start_i = 1'b0;
      if3.start_i = 1'b0;
      test_reset();
      test_frame();
      test_timeout();
      test_overrun();
      test_cs_mode();
      test_single();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
